// File: rtl/dbuf_pkg.sv
// Shared types and default sizing for the double-buffered register bank.
package dbuf_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } dbuf_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CH    = 4;

endpackage

// File: rtl/dbuf_cell.sv
// One channel of the bank: shadow register, active register, dirty flag and
// complemented output.
module dbuf_cell
  import dbuf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             copy_en_i,
  input  logic             xparent_en_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] q_n_o,
  output logic             dirty_o
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q;
  logic             dirty_q;

  assign shadow_d = wr_en_i ? wr_data_i : shadow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      dirty_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (copy_en_i) begin
        // No writes are accepted during a copy, so shadow_q is already final.
        active_q <= shadow_q;
        dirty_q  <= 1'b0;
      end else if (xparent_en_i) begin
        active_q <= shadow_d;
      end else if (wr_en_i) begin
        dirty_q <= 1'b1;
      end
    end
  end

  assign q_o     = active_q;
  assign q_n_o   = ~active_q;
  assign dirty_o = dirty_q;

endmodule

// File: rtl/dbuf_reg_bank.sv
// Double-buffered register bank: channel writes land in shadow registers and
// a commit copies all of them to the active outputs atomically.
// Optional macro DBUF_TRANSPARENT_EN adds the xparent input (shadow-to-active
// pass-through while idle).
module dbuf_reg_bank
  import dbuf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CH    = DEF_CH
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef DBUF_TRANSPARENT_EN
  input  logic                  xparent,
`endif
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [$clog2(CH)-1:0] wr_ch,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  commit,
  output logic                  commit_ack,
  output logic [CH*WIDTH-1:0]   q,
  output logic [CH*WIDTH-1:0]   q_n,
  output logic [CH-1:0]         dirty
);

  localparam int CHW = $clog2(CH);

  dbuf_state_e state_q;
  logic        commit_ack_q;
  logic        wr_fire;
  logic        copy_en;
  logic        xparent_en;
  logic [CH-1:0] wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      commit_ack_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          commit_ack_q <= 1'b0;
          if (commit) state_q <= COMMIT;
        end
        COMMIT: begin
          state_q      <= IDLE;
          commit_ack_q <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          commit_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready   = (state_q == IDLE) && !rst;
  assign wr_fire    = wr_valid && wr_ready;
  assign copy_en    = (state_q == COMMIT);
  assign commit_ack = commit_ack_q;

`ifdef DBUF_TRANSPARENT_EN
  assign xparent_en = (state_q == IDLE) && xparent;
`else
  assign xparent_en = 1'b0;
`endif

  // Out-of-range channel indices match no cell, so such writes vanish.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_cell
      assign wr_en[gi] = wr_fire && (wr_ch == CHW'(gi));

      dbuf_cell #(
        .WIDTH(WIDTH)
      ) u_cell (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wr_en[gi]),
        .wr_data_i   (wr_data),
        .copy_en_i   (copy_en),
        .xparent_en_i(xparent_en),
        .q_o         (q[gi*WIDTH +: WIDTH]),
        .q_n_o       (q_n[gi*WIDTH +: WIDTH]),
        .dirty_o     (dirty[gi])
      );
    end
  endgenerate

endmodule

// File: doc/dbuf_reg_bank.md
DBUF_REG_BANK -- requirements
Module: dbuf_reg_bank

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per channel.
REQ-002 Parameter: CH, default 4, number of channels (≥2, need not be a power of two).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: wr_valid  input  1  write request.
REQ-006 Port: wr_ready  output  1  write accept; a write transfers when wr_valid && wr_ready at a rising edge.
REQ-007 Port: wr_ch  input  $clog2(CH)  target channel index.
REQ-008 Port: wr_data  input  WIDTH  data written to the shadow register of wr_ch.
REQ-009 Port: commit  input  1  request atomic copy of all shadow registers to active registers.
REQ-010 Port: commit_ack  output  1  one-cycle pulse; new active values are visible.
REQ-011 Port: q  output  CH*WIDTH  active registers; channel i at bits [i*WIDTH +: WIDTH].
REQ-012 Port: q_n  output  CH*WIDTH  bitwise complement of q, always.
REQ-013 Port: dirty  output  CH  bit i set: shadow i written since last commit.
REQ-014 Port (DBUF_TRANSPARENT_EN only): xparent  input  1  transparent-mode select.

Function
REQ-015 FSM states IDLE and COMMIT; IDLE -> COMMIT when commit=1 is sampled in IDLE; COMMIT -> IDLE unconditionally after one cycle.
REQ-016 wr_ready shall be 1 in IDLE and 0 in COMMIT and while rst=1.
REQ-017 Accepted write: shadow[wr_ch] <= wr_data, dirty[wr_ch] <= 1 at the same edge.
REQ-018 Write with wr_ch ≥ CH shall be accepted and discarded; no state changes.
REQ-019 Write and commit in the same IDLE cycle: the write lands in shadow and is included in the following commit.
REQ-020 In COMMIT: at the closing edge, active[i] <= shadow[i] for all i simultaneously, and dirty <= 0.
REQ-021 commit_ack shall be 1 exactly in the cycle after COMMIT, the first cycle q shows committed values; latency commit sample -> commit_ack = 2 cycles.
REQ-022 commit asserted while in COMMIT shall be ignored; commit asserted in the commit_ack cycle (IDLE) shall start a new commit.
REQ-023 Commit with dirty=0 shall still execute and pulse commit_ack; q unchanged.
REQ-024 q and q_n shall change only at commit edges, at reset, or in transparent mode.

Reset
REQ-025 While rst=1 at an edge: shadow=0, active=0 (q=0, q_n=all ones), dirty=0, state=IDLE, commit_ack=0.
REQ-026 Reset during COMMIT shall abort the copy; the cycle after reset deasserts is IDLE with no commit_ack.
REQ-027 Writes and commits presented while rst=1 shall be ignored.

Configuration
REQ-028 Macro DBUF_TRANSPARENT_EN: when defined, port xparent exists; in IDLE with xparent=1, at every edge active[i] <= shadow value after any same-edge write, so q tracks accepted writes with 1-cycle latency and dirty is not set; commit behaviour is unchanged.
REQ-029 Without DBUF_TRANSPARENT_EN: port xparent absent; active registers update only via commit or reset.

Structure
REQ-030 Package dbuf_pkg shall hold the FSM state type (IDLE, COMMIT) and default WIDTH/CH constants.
REQ-031 Sub-module dbuf_cell shall implement one channel (shadow, active, dirty bit, q_n inversion); dbuf_reg_bank shall instantiate CH copies and contain the FSM, decode and handshake.

Verification
REQ-032 Reset, then write ch1=0xA5 -> dirty=4'b0010, q=0, q_n ch1=0xFF; commit -> commit_ack 2 cycles later, q ch1=0xA5, q_n ch1=0x5A, dirty=0.
REQ-033 Write ch0=0x11 with commit in the same cycle -> commit includes 0x11; wr_ready=0 in the following cycle; the write presented then stalls until the IDLE cycle.
REQ-034 CH=3, write wr_ch=3 data 0xFF -> accepted, q and dirty unchanged after commit.
REQ-035 Assert rst in COMMIT cycle with shadow ch2=0x3C -> q=0, no commit_ack, dirty=0.
REQ-036 Back-to-back commit held high 4 cycles -> commit_ack pulses every 2 cycles, never in consecutive cycles.
REQ-037 With DBUF_TRANSPARENT_EN, xparent=1, write ch3=0x7E -> q ch3=0x7E one cycle later, dirty[3]=0; xparent=0, write 0x01 -> q holds 0x7E until commit.
